fft_ctrl: RTL and testbench

//   Sequencer for the in-place radix-2 DIT FFT engine. Loads N samples into the

---
 rtl/fft_pkg.sv | 26 ++
 rtl/fft_addr_gen.sv | 30 +++
 rtl/fft_ctrl.sv | 146 ++++++++++++++
 tb/tb_fft_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIT FFT sequencer.
// N/HALF_N/ADDR_W/TW_W describe the default 2048-point build; modules derive their own from LOG2N.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

   localparam int LOG2N_DEF = 11;
   localparam int N         = 1 << LOG2N_DEF;
   localparam int HALF_N    = N / 2;
   localparam int ADDR_W    = LOG2N_DEF;
   localparam int TW_W      = LOG2N_DEF - 1;

   // Reverses the low w bits of v; bits above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      logic [31:0] x;
      r = '0;
      x = v;
      for (int j = 0; j < w; j++) begin
         r = {r[30:0], x[0]};
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: (stage s, butterfly i) -> operand A/B addresses and twiddle index.
// Purely combinational, zero latency, no flow control.
module fft_addr_gen #(
   parameter int LOG2N = 11,
   parameter int SW    = $clog2(LOG2N + 1)
) (
   input  logic [SW-1:0]    s,
   input  logic [LOG2N-2:0] i,
   output logic [LOG2N-1:0] addr_a,
   output logic [LOG2N-1:0] addr_b,
   output logic [LOG2N-2:0] tw
);

   logic [LOG2N-1:0] ext_i;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] low_mask;
   logic [SW-1:0]    tw_sh;

   always_comb begin
      ext_i    = {1'b0, i};
      span     = LOG2N'(1) << s;
      low_mask = span - LOG2N'(1);
      // Insert a zero at bit s: the group index moves up one place, the offset stays put.
      addr_a   = (((ext_i >> s) << s) << 1) | (ext_i & low_mask);
      addr_b   = addr_a | span;
      tw_sh    = SW'(LOG2N - 1) - s;
      tw       = (i & low_mask[LOG2N-2:0]) << tw_sh;
   end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: bit-reversed load, LOG2N stages of N/2 butterflies, PIPE_LAT write-back delay.
// Load stalls on sample_valid low; compute never stalls. Define FFT_STAGE_SCALE_EN to add the bfu_scale output.
module fft_ctrl
   import fft_pkg::*;
#(
   parameter int LOG2N    = 11,
   parameter int PIPE_LAT = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       sample_valid,
   output logic                       sample_ready,
   output logic                       ld_we,
   output logic [LOG2N-1:0]           ld_addr,
   output logic                       rd_en,
   output logic [LOG2N-1:0]           rd_addr_a,
   output logic [LOG2N-1:0]           rd_addr_b,
   output logic [LOG2N-2:0]           tw_addr,
   output logic                       wb_en,
   output logic [LOG2N-1:0]           wb_addr_a,
   output logic [LOG2N-1:0]           wb_addr_b,
`ifdef FFT_STAGE_SCALE_EN
   output logic                       bfu_scale,
`endif
   output logic [$clog2(LOG2N+1)-1:0] stage
);

   localparam int AW  = LOG2N;
   localparam int TWW = LOG2N - 1;
   localparam int SW  = $clog2(LOG2N + 1);
   localparam int DW  = $clog2(PIPE_LAT + 1);
   localparam int PW  = 1 + 2 * AW;

   state_t          state;
   state_t          state_nx;
   logic            done_nx;
   logic [AW-1:0]   k;
   logic [TWW-1:0]  i;
   logic [SW-1:0]   s;
   logic [DW-1:0]   dcnt;
   logic            last_k;
   logic            last_i;
   logic            last_d;
   logic            last_s;
   logic [AW-1:0]   gen_a;
   logic [AW-1:0]   gen_b;
   logic [TWW-1:0]  gen_tw;
   logic [PW-1:0]   pipe [PIPE_LAT];

   fft_addr_gen #(
      .LOG2N (LOG2N),
      .SW    (SW)
   ) u_addr_gen (
      .s      (s),
      .i      (i),
      .addr_a (gen_a),
      .addr_b (gen_b),
      .tw     (gen_tw)
   );

   assign last_k = (k == '1);
   assign last_i = (i == '1);
   assign last_d = (dcnt == DW'(PIPE_LAT - 1));
   assign last_s = (s == SW'(LOG2N - 1));

   always_comb begin
      state_nx     = state;
      done_nx      = 1'b0;
      sample_ready = 1'b0;
      ld_we        = 1'b0;
      rd_en        = 1'b0;
      case (state)
         IDLE: begin
            // The done cycle is still IDLE; a start there is not taken as a new frame.
            if (start && !done) state_nx = LOAD;
         end
         LOAD: begin
            sample_ready = 1'b1;
            ld_we        = sample_valid;
            if (sample_valid && last_k) state_nx = COMPUTE;
         end
         COMPUTE: begin
            rd_en = 1'b1;
            if (last_i) state_nx = DRAIN;
         end
         DRAIN: begin
            if (last_d) begin
               if (last_s) begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = COMPUTE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         done  <= 1'b0;
         k     <= '0;
         i     <= '0;
         s     <= '0;
         dcnt  <= '0;
      end else begin
         state <= state_nx;
         done  <= done_nx;
         if (ld_we) k <= k + AW'(1);
         if (rd_en) i <= i + TWW'(1);
         if (state == DRAIN) begin
            dcnt <= last_d ? '0 : dcnt + DW'(1);
            if (last_d) s <= last_s ? '0 : s + SW'(1);
         end
      end
   end

   assign busy      = (state != IDLE);
   assign stage     = s;
   assign ld_addr   = ld_we ? AW'(bitrev(32'(k), LOG2N)) : '0;
   assign rd_addr_a = rd_en ? gen_a : '0;
   assign rd_addr_b = rd_en ? gen_b : '0;
   assign tw_addr   = rd_en ? gen_tw : '0;

   // Write-back delay line tracks the RAM read plus BFU output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int p = 0; p < PIPE_LAT; p++) pipe[p] <= '0;
      end else begin
         pipe[0] <= {rd_en, rd_addr_a, rd_addr_b};
         for (int p = 1; p < PIPE_LAT; p++) pipe[p] <= pipe[p-1];
      end
   end

   assign {wb_en, wb_addr_a, wb_addr_b} = pipe[PIPE_LAT-1];

`ifdef FFT_STAGE_SCALE_EN
   assign bfu_scale = wb_en;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl (LOG2N=3, PIPE_LAT=2) against a per-cycle trace built from the FFT index rules.
module tb_fft_ctrl;

   localparam int LOG2N    = 3;
   localparam int PIPE_LAT = 2;
   localparam int N        = 1 << LOG2N;
   localparam int HALF     = N / 2;
   localparam int SW       = $clog2(LOG2N + 1);
   localparam int TLEN     = LOG2N * (HALF + PIPE_LAT) + 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic             sample_valid;
   logic             busy;
   logic             done;
   logic             sample_ready;
   logic             ld_we;
   logic [LOG2N-1:0] ld_addr;
   logic             rd_en;
   logic [LOG2N-1:0] rd_addr_a;
   logic [LOG2N-1:0] rd_addr_b;
   logic [LOG2N-2:0] tw_addr;
   logic             wb_en;
   logic [LOG2N-1:0] wb_addr_a;
   logic [LOG2N-1:0] wb_addr_b;
   logic [SW-1:0]    stage;
`ifdef FFT_STAGE_SCALE_EN
   logic             bfu_scale;
`endif

   int checks = 0;
   int errors = 0;

   logic       ex_rd    [TLEN];
   logic       ex_wb    [TLEN];
   logic       ex_busy  [TLEN];
   logic       ex_done  [TLEN];
   int         ex_a     [TLEN];
   int         ex_b     [TLEN];
   int         ex_tw    [TLEN];
   int         ex_wa    [TLEN];
   int         ex_wbb   [TLEN];
   int         ex_stage [TLEN];
   logic [2:0] ld_order [N] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

   always #5 clk = ~clk;

   fft_ctrl #(
      .LOG2N    (LOG2N),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .ld_we        (ld_we),
      .ld_addr      (ld_addr),
      .rd_en        (rd_en),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .tw_addr      (tw_addr),
      .wb_en        (wb_en),
      .wb_addr_a    (wb_addr_a),
      .wb_addr_b    (wb_addr_b),
`ifdef FFT_STAGE_SCALE_EN
      .bfu_scale    (bfu_scale),
`endif
      .stage        (stage)
   );

   function automatic int ref_bitrev(input int kv);
      int r;
      int v;
      r = 0;
      v = kv;
      for (int j = 0; j < LOG2N; j++) begin
         r = r * 2 + v % 2;
         v = v / 2;
      end
      return r;
   endfunction

   function automatic logic [25:0] all_outs();
      logic sc;
`ifdef FFT_STAGE_SCALE_EN
      sc = bfu_scale;
`else
      sc = 1'b0;
`endif
      return {sc, busy, done, sample_ready, ld_we, ld_addr, rd_en, rd_addr_a, rd_addr_b,
              tw_addr, wb_en, wb_addr_a, wb_addr_b, stage};
   endfunction

   // Expected compute-phase trace, cycle 0 being the first cycle after the last accepted sample.
   task automatic build_model();
      int t;
      int span;
      for (int c = 0; c < TLEN; c++) begin
         ex_rd[c] = 1'b0;  ex_wb[c] = 1'b0;  ex_busy[c] = 1'b0;  ex_done[c] = 1'b0;
         ex_a[c] = 0;  ex_b[c] = 0;  ex_tw[c] = 0;  ex_wa[c] = 0;  ex_wbb[c] = 0;  ex_stage[c] = 0;
      end
      t = 0;
      for (int s = 0; s < LOG2N; s++) begin
         span = 1 << s;
         for (int c = t; c < t + HALF + PIPE_LAT; c++) begin
            ex_busy[c]  = 1'b1;
            ex_stage[c] = s;
         end
         for (int bi = 0; bi < HALF; bi++) begin
            ex_rd[t] = 1'b1;
            ex_a[t]  = (bi / span) * 2 * span + bi % span;
            ex_b[t]  = ex_a[t] + span;
            ex_tw[t] = (bi % span) * (HALF / span);
            ex_wb[t + PIPE_LAT]  = 1'b1;
            ex_wa[t + PIPE_LAT]  = ex_a[t];
            ex_wbb[t + PIPE_LAT] = ex_b[t];
            t++;
         end
         t += PIPE_LAT;
      end
      ex_done[t] = 1'b1;
   endtask

   // mode 0: valid held high, 1: random valid, 2: valid low for 3 cycles at k=3.
   task automatic run_frame(input int mode, input string name);
      int         k;
      int         cyc;
      int         stall;
      int         busy_cyc;
      logic       v;
      logic [7:0] obs;
      logic [7:0] expv;
      logic [2:0] exp_ld;
      k = 0;  cyc = 0;  stall = 0;  busy_cyc = 0;

      @(posedge clk); #1;
      start = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL %s idle_before_start got=%b exp=00", name, {busy, done});
      end

      while (k < N && cyc < 200) begin
         @(posedge clk); #1;
         start = 1'($urandom_range(0, 1));
         case (mode)
            0: v = 1'b1;
            1: v = 1'($urandom_range(0, 1));
            default: begin
               if (k == 3 && stall < 3) begin
                  v = 1'b0;
                  stall++;
               end else begin
                  v = 1'b1;
               end
            end
         endcase
         sample_valid = v;
         @(negedge clk);
         busy_cyc++;
         checks++;
         if ({busy, sample_ready, ld_we, rd_en} !== {1'b1, 1'b1, v, 1'b0}) begin
            errors++;
            $display("FAIL %s load_ctl k=%0d got=%b exp=%b", name, k,
                     {busy, sample_ready, ld_we, rd_en}, {1'b1, 1'b1, v, 1'b0});
         end
         if (v) begin
            exp_ld = (mode == 0) ? ld_order[k] : 3'(ref_bitrev(k));
            checks++;
            if (ld_addr !== exp_ld) begin
               errors++;
               $display("FAIL %s ld_addr k=%0d got=%0d exp=%0d", name, k, ld_addr, exp_ld);
            end
            k++;
         end
         cyc++;
      end
      if (k < N) begin
         checks++;
         errors++;
         $display("FAIL %s load_timeout accepted=%0d exp=%0d", name, k, N);
         return;
      end

      for (int t = 0; t < TLEN; t++) begin
         @(posedge clk); #1;
         sample_valid = 1'($urandom_range(0, 1));
         start = (t < TLEN - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(negedge clk);
         if (busy) busy_cyc++;
         obs  = {busy, done, sample_ready, ld_we, rd_en, wb_en, stage};
         expv = {ex_busy[t], ex_done[t], 1'b0, 1'b0, ex_rd[t], ex_wb[t], SW'(ex_stage[t])};
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s compute_ctl t=%0d got=%b exp=%b", name, t, obs, expv);
         end
         if (ex_rd[t]) begin
            checks++;
            if ({rd_addr_a, rd_addr_b, tw_addr} !== {3'(ex_a[t]), 3'(ex_b[t]), 2'(ex_tw[t])}) begin
               errors++;
               $display("FAIL %s rd_addr t=%0d got=%0d,%0d,%0d exp=%0d,%0d,%0d", name, t,
                        rd_addr_a, rd_addr_b, tw_addr, ex_a[t], ex_b[t], ex_tw[t]);
            end
         end
         if (ex_wb[t]) begin
            checks++;
            if ({wb_addr_a, wb_addr_b} !== {3'(ex_wa[t]), 3'(ex_wbb[t])}) begin
               errors++;
               $display("FAIL %s wb_addr t=%0d got=%0d,%0d exp=%0d,%0d", name, t,
                        wb_addr_a, wb_addr_b, ex_wa[t], ex_wbb[t]);
            end
         end
         if (t == HALF + PIPE_LAT + 3) begin
            checks++;
            if ({rd_addr_a, rd_addr_b, tw_addr} !== {3'd5, 3'd7, 2'd2}) begin
               errors++;
               $display("FAIL %s stage1_i3_rd got=%0d,%0d,%0d exp=5,7,2", name,
                        rd_addr_a, rd_addr_b, tw_addr);
            end
         end
         if (t == HALF + 2 * PIPE_LAT + 3) begin
            checks++;
            if ({wb_en, wb_addr_a, wb_addr_b} !== {1'b1, 3'd5, 3'd7}) begin
               errors++;
               $display("FAIL %s stage1_i3_wb got=%b,%0d,%0d exp=1,5,7", name,
                        wb_en, wb_addr_a, wb_addr_b);
            end
         end
`ifdef FFT_STAGE_SCALE_EN
         checks++;
         if (bfu_scale !== ex_wb[t]) begin
            errors++;
            $display("FAIL %s bfu_scale t=%0d got=%b exp=%b", name, t, bfu_scale, ex_wb[t]);
         end
`endif
      end

      checks++;
      if (busy_cyc != cyc + LOG2N * (HALF + PIPE_LAT)) begin
         errors++;
         $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_cyc,
                  cyc + LOG2N * (HALF + PIPE_LAT));
      end

      repeat (3) begin
         @(posedge clk); #1;
         start = 1'b0;
         sample_valid = 1'b0;
         @(negedge clk);
         checks++;
         if ({busy, done, rd_en, wb_en} !== 4'b0000) begin
            errors++;
            $display("FAIL %s post_idle got=%b exp=0000", name, {busy, done, rd_en, wb_en});
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", all_outs());
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_load_order();
      run_frame(0, "load_order");
   endtask

   task automatic test_random_valid();
      for (int r = 0; r < 3; r++) run_frame(1, "random_valid");
   endtask

   task automatic test_stall();
      run_frame(2, "valid_stall");
   endtask

   task automatic test_back_to_back();
      run_frame(0, "back_to_back_a");
      run_frame(0, "back_to_back_b");
   endtask

   task automatic test_reset_mid_compute();
      @(posedge clk); #1;
      start = 1'b1;
      repeat (N) begin
         @(posedge clk); #1;
         start = 1'b0;
         sample_valid = 1'b1;
      end
      repeat (3) begin
         @(posedge clk); #1;
         sample_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({busy, rd_en} !== 2'b11) begin
         errors++;
         $display("FAIL mid_reset_in_compute got=%b exp=11", {busy, rd_en});
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (all_outs() !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got=%h exp=0", all_outs());
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checks++;
         if ({busy, done, rd_en, wb_en} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_quiet c=%0d got=%b exp=0000", c, {busy, done, rd_en, wb_en});
         end
      end
   endtask

   task automatic test_frame_after_reset();
      run_frame(1, "after_reset");
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      sample_valid = 1'b0;
      build_model();
      test_reset();
      test_load_order();
      test_random_valid();
      test_stall();
      test_back_to_back();
      test_reset_mid_compute();
      test_frame_after_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
